uart_fifo_wr_arb: RTL
=====================

Name: uart_fifo_wr_arb

Overview:
Round-robin arbiter that shares the 32-bit write port of the UART prefetch FIFO among NUM_REQ producers (conv result channels, status reporter, debug tap).
- Grants one requester at a time for a burst: up to MAX_BURST words, or ends early on req_last.
- Forwards beats under FIFO backpressure (fifo_wr_vld).
- Sits entirely in the FIFO write clock domain, directly in front of the FIFO write side.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 32, word width; must equal the FIFO write width.
- MAX_BURST, 8, maximum words per grant (1..256).

Ports:
- wr_clk  input  1  write-domain clock.
- wr_rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  NUM_REQ  per-requester word valid.
- req_data  input  NUM_REQ*DATA_WIDTH  packed words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  input  NUM_REQ  last word of requester's packet.
- req_ready  output  NUM_REQ  per-requester accept.
- fifo_wr_en  output  1  FIFO write enable.
- fifo_wr_data  output  DATA_WIDTH  FIFO write data.
- fifo_wr_vld  input  1  FIFO can accept a word this cycle.
- grant_id  output  clog2(NUM_REQ) (min 1)  currently granted requester.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock (wr_clk); reset is asynchronous and active-low (wr_rst_n).
- Reset values:
  - state = IDLE, rr_ptr = 0, grant_id = 0, beat_cnt = 0, busy = 0.
  - req_ready, fifo_wr_en and fifo_wr_data are all 0.
  - Reset mid-burst aborts immediately; fifo_wr_en deasserts in the same cycle reset asserts. The partial burst is not replayed.
- Beat definition: beat = req_valid[grant_id] & req_ready[grant_id]. Producers hold data stable while valid && !ready.
- Output timing:
  - req_ready[i] = (state==XFER) & (grant_id==i) & fifo_wr_vld. Combinational; all other bits 0.
  - fifo_wr_en = beat, fifo_wr_data = granted slice. Combinational pass-through, zero latency.
  - fifo_wr_data is 0 when fifo_wr_en is 0.
- States:
  - IDLE: if any req_valid, pick the first valid index searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
    - Register it into grant_id, clear beat_cnt.
    - Next state is XFER, or HDR when ARB_HEADER_EN is defined.
    - With no valid requester, stay in IDLE.
    - IDLE always costs exactly one bubble cycle between bursts.
  - HDR (macro only): see Optional Feature.
  - XFER: on each beat, beat_cnt += 1.
    - Burst ends on a beat with req_last=1, or on the beat where beat_cnt == MAX_BURST-1.
    - At burst end: next state IDLE, rr_ptr = grant_id+1 (wraps to 0 at NUM_REQ).
    - No beat (valid low or fifo_wr_vld low): hold state, grant and count. No timeout; the grant is held until burst end.
- Boundary cases:
  - MAX_BURST=1: every beat ends the burst.
  - req_last and beat_cnt limit on the same beat: single end-of-burst, no double pointer advance.
  - Requester truncated by MAX_BURST: resumes its packet on a later grant; req_last is only meaningful for ending a grant.
  - Deasserting req_valid mid-burst is legal; the grant is kept.
- beat_cnt width: clog2(MAX_BURST)+1. It never exceeds MAX_BURST-1 in XFER.

Optional Feature:
Macro: ARB_HEADER_EN.
- Defined:
  - IDLE transitions to HDR after selecting a grant.
  - HDR drives fifo_wr_en = fifo_wr_vld, fifo_wr_data = {8'hA5, 8'(grant_id), 16'(burst_seq)}; req_ready is all 0 in HDR.
  - When fifo_wr_vld is 1: header written, go to XFER. Otherwise hold in HDR.
  - burst_seq is a 16-bit counter, reset 0, incremented at every burst end, wraps at 16'hFFFF→0.
- Undefined: HDR state, burst_seq and header logic are absent; IDLE goes directly to XFER.

Test Plan:
- Single requester 0 sends 3 words (0x11,0x22,0x33 with last on 0x33), fifo_wr_vld=1:
  - XFER starts 1 cycle after valid; fifo_wr_en high 3 consecutive cycles with those words.
  - Then 1 IDLE cycle; rr_ptr=1.
- All 4 requesters valid continuously with 1-word packets: grant order 0,1,2,3,0,1; one bubble per grant.
- Requester 2 streams 20 words, MAX_BURST=8, others idle: three grants of 8, 8, 4 words, each separated by 1 IDLE cycle; data order preserved.
- Mid-burst fifo_wr_vld=0 for 5 cycles: req_ready and fifo_wr_en low for those 5 cycles; grant_id and beat_cnt unchanged; no word lost or duplicated.
- wr_rst_n asserted on the 4th beat of an 8-word burst: fifo_wr_en=0 in the same cycle; after release state=IDLE, rr_ptr=0, busy=0.
- ARB_HEADER_EN defined, requester 1 sends 2 words, then requester 3 sends 1 word:
  - FIFO receives 0xA5010000, w0, w1, then 0xA5030001, w0.
  - Header stalls correctly when fifo_wr_vld=0.

Source files
------------

// File: rtl/uart_fifo_wr_arb.sv
// uart_fifo_wr_arb
//   Round-robin arbiter sharing the UART prefetch FIFO write port among NUM_REQ producers.
//   A grant lasts for one burst: up to MAX_BURST beats, or fewer if the producer flags req_last.
//   Every burst is followed by exactly one IDLE bubble cycle.
//
// Optional feature (macro ARB_HEADER_EN): each burst is preceded by a header word
//   {8'hA5, grant_id, burst_seq[15:0]} written from a HDR state.
//
// Ports
//   wr_clk, wr_rst_n  write-domain clock, asynchronous active-low reset
//   req_valid/req_data/req_last  per-requester word valid, packed data, end-of-packet
//   req_ready         per-requester accept (combinational)
//   fifo_wr_en/fifo_wr_data      FIFO write side (combinational pass-through)
//   fifo_wr_vld       FIFO can accept a word this cycle
//   grant_id          currently granted requester
//   busy              high whenever the arbiter is not in IDLE
module uart_fifo_wr_arb #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 8,
    localparam int unsigned IdW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int unsigned CntW      = $clog2(MAX_BURST) + 1
) (
    input  logic                          wr_clk,
    input  logic                          wr_rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    input  logic                          fifo_wr_vld,
    output logic [IdW-1:0]                grant_id,
    output logic                          busy
);

`ifdef ARB_HEADER_EN
    typedef enum logic [1:0] {StIdle, StHdr, StXfer} state_e;
    logic [15:0] burst_seq_q;
`else
    typedef enum logic [1:0] {StIdle, StXfer} state_e;
`endif

    state_e          state_q;
    logic [IdW-1:0]  rr_ptr_q;
    logic [CntW-1:0] beat_cnt_q;

    logic            found;
    logic [IdW-1:0]  pick;
    logic [IdW-1:0]  sel;
    int unsigned     idx;
    logic            beat;
    logic            burst_end;
    logic [IdW-1:0]  nxt_ptr;

    assign busy = (state_q != StIdle);

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        sel   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(rr_ptr_q) + i) % NUM_REQ;
            sel = IdW'(idx);
            if (!found && req_valid[sel]) begin
                found = 1'b1;
                pick  = sel;
            end
        end
    end

    always_comb begin
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
        if (state_q == StXfer && fifo_wr_vld) begin
            req_ready[grant_id] = 1'b1;
        end
        beat = req_valid[grant_id] & req_ready[grant_id];
        if (beat) begin
            fifo_wr_en   = 1'b1;
            fifo_wr_data = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
        end
`ifdef ARB_HEADER_EN
        if (state_q == StHdr && fifo_wr_vld) begin
            fifo_wr_en   = 1'b1;
            fifo_wr_data = DATA_WIDTH'({8'hA5, 8'(grant_id), burst_seq_q});
        end
`endif
    end

    // req_last and the MAX_BURST limit on the same beat collapse into one burst end.
    assign burst_end = beat & (req_last[grant_id] | (beat_cnt_q == CntW'(MAX_BURST - 1)));
    assign nxt_ptr   = (grant_id == IdW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            grant_id    <= '0;
            beat_cnt_q  <= '0;
`ifdef ARB_HEADER_EN
            burst_seq_q <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (found) begin
                        grant_id   <= pick;
                        beat_cnt_q <= '0;
`ifdef ARB_HEADER_EN
                        state_q    <= StHdr;
`else
                        state_q    <= StXfer;
`endif
                    end
                end
`ifdef ARB_HEADER_EN
                StHdr: begin
                    if (fifo_wr_vld) begin
                        state_q <= StXfer;
                    end
                end
`endif
                StXfer: begin
                    if (burst_end) begin
                        state_q     <= StIdle;
                        rr_ptr_q    <= nxt_ptr;
                        beat_cnt_q  <= '0;
`ifdef ARB_HEADER_EN
                        burst_seq_q <= burst_seq_q + 16'd1;
`endif
                    end else if (beat) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
